// File: rtl/vga_pkg.sv
// Shared VGA timing types, standard mode presets and a helper that derives
// the total line/frame lengths from a timing description.
package vga_pkg;

    // One axis of a raster mode: visible span, porches, sync width, polarity.
    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
        logic        pol;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
    } vga_totals_t;

    // Per-pixel flags carried through the alignment delay line.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic line_start;
        logic frame_start;
    } vga_flags_t;

    localparam int FLAGS_W = $bits(vga_flags_t);

    localparam vga_timing_t VGA_640x480 = '{
        h: '{active: 16'd640,  fp: 16'd16, sync: 16'd96,  bp: 16'd48,  pol: 1'b0},
        v: '{active: 16'd480,  fp: 16'd10, sync: 16'd2,   bp: 16'd33,  pol: 1'b0}
    };

    localparam vga_timing_t SVGA_800x600 = '{
        h: '{active: 16'd800,  fp: 16'd40, sync: 16'd128, bp: 16'd88,  pol: 1'b1},
        v: '{active: 16'd600,  fp: 16'd1,  sync: 16'd4,   bp: 16'd23,  pol: 1'b1}
    };

    localparam vga_timing_t XGA_1024x768 = '{
        h: '{active: 16'd1024, fp: 16'd24, sync: 16'd136, bp: 16'd160, pol: 1'b0},
        v: '{active: 16'd768,  fp: 16'd3,  sync: 16'd6,   bp: 16'd29,  pol: 1'b0}
    };

    // Pixels per line and lines per frame for a mode.
    function automatic vga_totals_t totals(input vga_timing_t t);
        vga_totals_t r;
        r.h = t.h.active + t.h.fp + t.h.sync + t.h.bp;
        r.v = t.v.active + t.v.fp + t.v.sync + t.v.bp;
        return r;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-qualified register chain used to align the raster flags with the
// latency of a downstream pixel pipeline. DEPTH=0 is a plain wire.
module vga_delay_line #(
    parameter int               DEPTH     = 0,
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic             clk,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, en, flush};
        assign dout        = din;
    end else begin : g_chain
        logic [WIDTH-1:0] stage [DEPTH];

        // Shift one position per enabled clock; flush wins over the shift.
        always_ff @(posedge clk) begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= FLUSH_VAL;
            end else if (en) begin
                // NOTE: non-blocking so every stage takes its neighbour's old value, not the new one.
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, sync, blanking
// and line/frame start flags, with optional flag delay for pipeline alignment.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_ACTIVE  = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PIPE_DLY  = 0,
    parameter int X_W       = 11,
    parameter int Y_W       = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_en,
    input  logic           restart,
    output logic [X_W-1:0] pixel_x,
    output logic [Y_W-1:0] pixel_y,
    output logic           active_video,
    output logic           hsync,
    output logic           vsync,
    output logic           line_start,
    output logic           frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((64'd1 << X_W) < 64'(H_TOTAL)) begin : g_bad_x_w
        $error("X_W too narrow for H_TOTAL");
    end
    if ((64'd1 << Y_W) < 64'(V_TOTAL)) begin : g_bad_y_w
        $error("Y_W too narrow for V_TOTAL");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_bad_dly
        $error("PIPE_DLY must be 0..15");
    end

    localparam logic [X_W-1:0] H_ACT_END = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_BEG    = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END    = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [X_W-1:0] H_LAST    = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_ACT_END = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_BEG    = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END    = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [Y_W-1:0] V_LAST    = Y_W'(V_TOTAL - 1);

    // Flag values shown while blanked by reset or a flush.
    localparam vga_flags_t BLANK = '{
        active: 1'b0, hsync: ~HSYNC_POL, vsync: ~VSYNC_POL,
        line_start: 1'b0, frame_start: 1'b0
    };

    // Flags for a raster position; vsync spans whole lines independent of hsync.
    function automatic vga_flags_t decode(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        vga_flags_t f;
        f.active      = (x < H_ACT_END) && (y < V_ACT_END);
        f.hsync       = ((x >= HS_BEG) && (x < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        f.vsync       = ((y >= VS_BEG) && (y < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        f.line_start  = (x == '0);
        f.frame_start = (x == '0) && (y == '0);
        return f;
    endfunction

    logic           primed;
    logic [X_W-1:0] x_q, x_nxt;
    logic [Y_W-1:0] y_q, y_nxt;
    vga_flags_t     flags0_q, flags0_nxt, flags_dly;

    // Next raster position: first enable after reset loads (0,0), then count and wrap.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        x_nxt = x_q;
        y_nxt = y_q;
        if (!primed) begin
            x_nxt = '0;
            y_nxt = '0;
        end else if (x_q == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y_q == V_LAST) ? '0 : y_q + 1'b1;
        end else begin
            x_nxt = x_q + 1'b1;
        end
        flags0_nxt = decode(x_nxt, y_nxt);
    end

    // Position and stage-0 flag registers; reset beats restart beats pix_en.
    always_ff @(posedge clk) begin
        if (!reset) begin
            primed   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            flags0_q <= BLANK;
        end else if (restart) begin
            primed   <= 1'b1;
            x_q      <= '0;
            y_q      <= '0;
            flags0_q <= decode('0, '0);
        end else if (pix_en) begin
            primed   <= 1'b1;
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            flags0_q <= flags0_nxt;
        end
    end

    vga_delay_line #(
        .DEPTH    (PIPE_DLY),
        .WIDTH    (FLAGS_W),
        .FLUSH_VAL(BLANK)
    ) u_dly (
        .clk  (clk),
        .en   (pix_en),
        .flush(!reset || restart),
        .din  (flags0_q),
        .dout (flags_dly)
    );

    assign pixel_x      = x_q;
    assign pixel_y      = y_q;
    assign active_video = flags_dly.active;
    assign hsync        = flags_dly.hsync;
    assign vsync        = flags_dly.vsync;
    assign line_start   = flags_dly.line_start;
    assign frame_start  = flags_dly.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a 16x8 test mode: one instance with no flag
// delay and active-low syncs, one with PIPE_DLY=4 and active-high syncs.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam vga_timing_t SMALL = '{
        h: '{active: 16'd8, fp: 16'd2, sync: 16'd3, bp: 16'd3, pol: 1'b0},
        v: '{active: 16'd4, fp: 16'd1, sync: 16'd2, bp: 16'd1, pol: 1'b0}
    };
    localparam int HA = SMALL.h.active;
    localparam int HF = SMALL.h.fp;
    localparam int HS = SMALL.h.sync;
    localparam int VA = SMALL.v.active;
    localparam int VF = SMALL.v.fp;
    localparam int VS = SMALL.v.sync;
    localparam vga_totals_t TOT = totals(SMALL);
    localparam int HT = TOT.h;
    localparam int VT = TOT.v;

    logic clk = 1'b0;
    logic reset, pix_en, restart;

    logic [10:0] x0, x4;
    logic [9:0]  y0, y4;
    logic a0, h0, v0, ls0, fs0;
    logic a4, h4, v4, ls4, fs4;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(SMALL.h.active), .H_FP(SMALL.h.fp), .H_SYNC(SMALL.h.sync), .H_BP(SMALL.h.bp),
        .V_ACTIVE(SMALL.v.active), .V_FP(SMALL.v.fp), .V_SYNC(SMALL.v.sync), .V_BP(SMALL.v.bp),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DLY(0), .X_W(11), .Y_W(10)
    ) u_dut0 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .restart(restart),
        .pixel_x(x0), .pixel_y(y0), .active_video(a0), .hsync(h0), .vsync(v0),
        .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(SMALL.h.active), .H_FP(SMALL.h.fp), .H_SYNC(SMALL.h.sync), .H_BP(SMALL.h.bp),
        .V_ACTIVE(SMALL.v.active), .V_FP(SMALL.v.fp), .V_SYNC(SMALL.v.sync), .V_BP(SMALL.v.bp),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DLY(4), .X_W(11), .Y_W(10)
    ) u_dut4 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .restart(restart),
        .pixel_x(x4), .pixel_y(y4), .active_video(a4), .hsync(h4), .vsync(v4),
        .line_start(ls4), .frame_start(fs4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the raster is just the count of enabled pixels since the last load.
    bit m_primed = 1'b0;
    int m_n = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_primed <= 1'b0;
            m_n      <= 0;
        end else if (restart) begin
            m_primed <= 1'b1;
            m_n      <= 0;
        end else if (pix_en) begin
            m_primed <= 1'b1;
            m_n      <= m_primed ? m_n + 1 : 0;
        end
    end

    // Expected {x, y, active, hsync, vsync, line_start, frame_start}.
    function automatic logic [25:0] expect_vec(input bit primed, input int n, input int dly,
                                               input bit hpol, input bit vpol);
        int x, y, k, kx, ky;
        logic a, h, v, ls, fs;
        x = 0; y = 0;
        a = 1'b0; h = ~hpol; v = ~vpol; ls = 1'b0; fs = 1'b0;
        if (primed) begin
            x = n % HT;
            y = (n / HT) % VT;
            k = n - dly;
            if (k >= 0) begin
                kx = k % HT;
                ky = (k / HT) % VT;
                a  = (kx < HA) && (ky < VA);
                h  = (kx >= HA + HF && kx < HA + HF + HS) ? hpol : ~hpol;
                v  = (ky >= VA + VF && ky < VA + VF + VS) ? vpol : ~vpol;
                ls = (kx == 0);
                fs = (kx == 0) && (ky == 0);
            end
        end
        return {11'(x), 10'(y), a, h, v, ls, fs};
    endfunction

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("dly0_raster", 32'({x0, y0, a0, h0, v0, ls0, fs0}),
                  32'(expect_vec(m_primed, m_n, 0, 1'b0, 1'b0)));
            check("dly4_raster", 32'({x4, y4, a4, h4, v4, ls4, fs4}),
                  32'(expect_vec(m_primed, m_n, 4, 1'b1, 1'b1)));
        end
    end

    // Wait (bounded) until the undelayed instance shows position (wx, wy).
    task automatic wait_xy(input int wx, input int wy);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (x0 == 11'(wx) && y0 == 10'(wy)) hit = 1'b1;
        end
        check($sformatf("reach_%0d_%0d", wx, wy), 32'(hit), 32'd1);
    endtask

    initial begin
        int cnt;
        int run;
        int first_run;

        reset = 1'b0; pix_en = 1'b0; restart = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;

        // Reset values.
        check("rst_x", 32'(x0), 32'd0);
        check("rst_active", 32'(a0), 32'd0);
        check("rst_hsync_lowpol", 32'(h0), 32'd1);
        check("rst_vsync_lowpol", 32'(v0), 32'd1);
        check("rst_hsync_highpol", 32'(h4), 32'd0);
        check("rst_frame_start", 32'(fs0), 32'd0);

        // Release without enable: still unprimed, nothing moves.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("unprimed_hold_ls", 32'(ls0), 32'd0);

        // First enable loads (0,0) with its flags.
        pix_en = 1'b1;
        @(negedge clk);
        check("prime_xy", 32'({x0, y0}), 32'd0);
        check("prime_active", 32'(a0), 32'd1);
        check("prime_frame_start", 32'(fs0), 32'd1);
        check("prime_dly4_blank_fs", 32'(fs4), 32'd0);

        // Horizontal sync window x=10..12, and the 4-clock flag lag.
        wait_xy(9, 0);  check("hs_x9", 32'(h0), 32'd1);
        wait_xy(10, 0); check("hs_x10", 32'(h0), 32'd0);
        wait_xy(11, 0); check("dly4_active_x11", 32'(a4), 32'd1);
        wait_xy(12, 0); check("hs_x12", 32'(h0), 32'd0);
                        check("dly4_active_x12", 32'(a4), 32'd0);
        wait_xy(13, 0); check("hs_x13", 32'(h0), 32'd1);
                        check("dly4_hs_x13", 32'(h4), 32'd0);
        wait_xy(14, 0); check("dly4_hs_x14", 32'(h4), 32'd1);

        // Vertical sync on lines 5..6.
        wait_xy(15, 4); check("vs_y4", 32'(v0), 32'd1);
        wait_xy(0, 5);  check("vs_y5", 32'(v0), 32'd0);
        wait_xy(15, 6); check("vs_y6", 32'(v0), 32'd0);
        wait_xy(0, 7);  check("vs_y7", 32'(v0), 32'd1);

        // Frame period.
        wait_xy(0, 0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!fs0 && cnt < 300);
        check("fs_period", 32'(cnt), 32'd128);

        // Restart mid-frame at (5,3).
        wait_xy(5, 3);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_xy", 32'({x0, y0}), 32'd0);
        check("restart_fs", 32'(fs0), 32'd1);
        check("restart_dly4_active", 32'(a4), 32'd0);
        repeat (3) @(negedge clk);
        check("restart_dly4_fs_3clk", 32'(fs4), 32'd0);
        @(negedge clk);
        check("restart_dly4_fs_4clk", 32'(fs4), 32'd1);

        // Enable every third clock: flags stretch over stalls.
        restart = 1'b1;
        pix_en  = 1'b0;
        @(negedge clk);
        restart   = 1'b0;
        run       = 0;
        first_run = 0;
        for (int i = 0; i < 420; i++) begin
            pix_en = (i % 3 == 0);
            @(negedge clk);
            if (fs0) run++;
            else if (run != 0 && first_run == 0) first_run = run;
        end
        check("fs_stretch_3clk", 32'(first_run), 32'd3);

        // Reset mid-frame, together with restart: reset wins.
        pix_en = 1'b1;
        wait_xy(6, 2);
        reset   = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        check("midrst_xy", 32'({x0, y0}), 32'd0);
        check("midrst_active", 32'(a0), 32'd0);
        check("midrst_hsync", 32'(h0), 32'd1);
        check("midrst_fs", 32'(fs0), 32'd0);
        reset   = 1'b1;
        restart = 1'b0;
        @(negedge clk);
        check("midrst_reprime_fs", 32'(fs0), 32'd1);
        repeat (200) @(negedge clk);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to vga_timing. Generates raster counters, sync and blanking for any VESA-style mode set at elaboration time, with selectable sync polarity. Adds a pixel-clock enable, a synchronous frame restart, line/frame start flags, and a configurable output delay that aligns the sync/blank outputs with downstream pixel-pipeline latency. Sits between the clock source and the framebuffer/pixel pipeline.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, hsync pulse width (pixels)
H_BP, 160, horizontal back porch (pixels); H_TOTAL = sum = 1344
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vsync pulse width (lines)
V_BP, 29, vertical back porch (lines); V_TOTAL = sum = 806
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync
PIPE_DLY, 0, extra enable-qualified stages on the flag outputs (0..15)
X_W, 11, pixel_x width; must satisfy 2**X_W >= H_TOTAL (elaboration assertion)
Y_W, 10, pixel_y width; must satisfy 2**Y_W >= V_TOTAL (elaboration assertion)

Ports:
clk  in  1  pixel-domain clock
reset  in  1  synchronous, active-low reset (reset==0 resets)
pix_en  in  1  pixel advance enable; all state holds while 0
restart  in  1  synchronous frame restart to (0,0)
pixel_x  out  X_W  current horizontal position, 0..H_TOTAL-1
pixel_y  out  Y_W  current vertical position, 0..V_TOTAL-1
active_video  out  1  pixel inside visible area (delayed by PIPE_DLY)
hsync  out  1  horizontal sync at HSYNC_POL level when asserted (delayed)
vsync  out  1  vertical sync at VSYNC_POL level when asserted (delayed)
line_start  out  1  high while current pixel has x==0 (delayed)
frame_start  out  1  high while current pixel is (0,0) (delayed)

Behaviour:
- All outputs registered. Priority: reset > restart > pix_en.
- Reset: pixel_x=0, pixel_y=0, active_video=0, line_start=0, frame_start=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL; internal primed=0; delay line flushed to the same blank values.
- First pix_en=1 cycle after reset (primed=0): loads position (0,0) with its flags, sets primed=1. Outputs show (0,0) on the following clock.
- Each later pix_en=1 cycle: x<=x+1; when x==H_TOTAL-1, x<=0 and y<=y+1; when additionally y==V_TOTAL-1, y<=0. No other wrap points.
- Stage-0 flag decode from the loaded position: active = x<H_ACTIVE && y<V_ACTIVE; hsync asserted iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; vsync asserted iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (whole lines, hsync-independent); line_start = x==0; frame_start = x==0 && y==0.
- pixel_x/pixel_y are never delayed. The five flags pass PIPE_DLY further stages; each stage shifts only when pix_en=1. With PIPE_DLY=0, flags align with pixel_x/pixel_y.
- pix_en=0: counters, flags and delay line hold. Flags are per-pixel levels, so a stall stretches them.
- restart=1, regardless of pix_en: next clock position=(0,0) with its stage-0 flags, primed=1, delay stages flushed to blank values. Held restart keeps the generator at (0,0).
- Reset or restart mid-line/frame: takes effect on the next clock with no partial-state residue.
- Default mode gives 1344*806 = 1,083,264 enabled cycles between frame_start rising edges.

Decomposition:
- Package vga_pkg: timing struct typedef (active, fp, sync, bp per axis, polarity); preset localparams VGA_640x480, SVGA_800x600, XGA_1024x768; function totals(). The module takes individual parameters, and the bench uses presets to fill them.
- Sub-module vga_delay_line: DEPTH (0 = wire-through) by WIDTH register chain with enable, synchronous flush, and parametrised flush value. Carries the 5 flags.

Test Plan:
- Small mode H=8/2/3/3 (total 16), V=4/1/2/1 (total 8), pix_en=1. Release reset -> (0,0) appears 1 clock after the first enable with active=1 and frame_start=1. hsync low exactly at x=10..12. vsync low on lines 5..6. frame_start recurs every 128 cycles.
- Same mode, pix_en high every 3rd cycle -> sequence identical to the previous scenario per enabled cycle. All outputs stable during gaps, and flag pulses stretch to 3 clocks.
- PIPE_DLY=4, pix_en=1 -> flags lag pixel_x by 4 clocks: active_video falls 4 clocks after pixel_x reaches 8, and hsync asserts while pixel_x==14.
- restart pulsed at (5,3) -> next clock (0,0) with frame_start=1. With PIPE_DLY=4, the delayed flags are blank for 4 clocks and then frame_start=1. restart simultaneous with reset=0 -> reset values.
- reset=0 asserted mid-frame -> next clock all outputs take reset values. Release -> restart from (0,0) via the primed path.
- Default XGA, polarity 0, ~2 frames -> frame_start period 1,083,264 cycles, 768 active lines, 1024 active pixels per line. Also repeat with HSYNC_POL=1 -> hsync asserted high for exactly 136 cycles per line.
